// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/PC stage: FSM states, width defaults
// and the fixed branch-target table.
package cpu_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int IDX_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int BR_ENTRIES = 1 << IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [BR_ENTRIES-1:0][PC_W_DEF-1:0] br_table_t;

  // Entries not listed here stay at address 0.
  function automatic br_table_t init_br_targets();
    br_table_t t;
    t     = '0;
    t[1]  = 10'd20;
    t[2]  = 10'd12;
    t[3]  = 10'd40;
    t[5]  = 10'd100;
    t[31] = 10'd1023;
    return t;
  endfunction

  localparam br_table_t BR_TARGETS = init_br_targets();

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: maps the instruction's target index to a PC
// using the read-only table from cpu_pkg.
module branch_lut
  import cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [IDX_W-1:0] tgt_idx_i,
  output logic [PC_W-1:0]  tgt_o
);

  logic [PC_W_DEF-1:0] raw;

  // Compare at 32 bits so a narrower index never aliases onto higher entries.
  always_comb begin
    raw = '0;
    for (int i = 0; i < BR_ENTRIES; i++) begin
      if (32'(tgt_idx_i) == $unsigned(i)) raw = BR_TARGETS[i];
    end
  end

  assign tgt_o = PC_W'(raw);

endmodule

// File: rtl/fetch_pc.sv
// Program counter / next-PC stage: run sequencing FSM, zero-bubble branch
// resolution from the register-file compare, and a saturating retire counter.
module fetch_pc
  import cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_en,
  input  logic             br_ne,
  input  logic             jmp,
  input  logic             cmp,
  input  logic [IDX_W-1:0] tgt_idx,
  output logic [PC_W-1:0]  pc,
  output logic             taken,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state_dbg
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, tgt;
  logic [CNT_W-1:0] ret_q, ret_d, ret_inc;
  logic             redirect;

  branch_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_branch_lut (
    .tgt_idx_i (tgt_idx),
    .tgt_o     (tgt)
  );

  // jmp dominates br_en simply by being OR-ed in unconditionally.
  assign redirect = jmp | (br_en & (cmp ^ br_ne));
  assign ret_inc  = (ret_q == {CNT_W{1'b1}}) ? ret_q : ret_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    taken   = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = RUN;
          ret_d   = '0;
        end
      end
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (halt) begin
          state_d = DONE;
          ret_d   = ret_inc;
        end else if (redirect) begin
          taken = 1'b1;
          pc_d  = tgt;
          ret_d = ret_inc;
        end else begin
          pc_d  = pc_q + PC_W'(1);
          ret_d = ret_inc;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          ret_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        ret_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end

  assign pc        = pc_q;
  assign retired   = ret_q;
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program-counter and next-PC stage that sits downstream of the register file's `cmp` output.
- Consumes the early equality result to resolve conditional branches in the same cycle the operands are read.
- Drives the instruction-memory address.
- Sequences start/halt of a program run and counts retired instructions for the bench and for the done handshake.

Parameters:
- PC_W, 10, width of the program counter and instruction address.
- IDX_W, 5, width of the branch-target index carried in the instruction.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset; forces the IDLE state.
- start  input  1  one-cycle pulse; begins a program run at address 0.
- stall  input  1  hold the PC this cycle; no retire.
- halt  input  1  the current instruction is a halt opcode.
- br_en  input  1  the current instruction is a conditional branch.
- br_ne  input  1  branch sense: 0 = branch if equal, 1 = branch if not equal.
- jmp  input  1  the current instruction is an unconditional jump.
- cmp  input  1  equality of the two operands read this cycle, from the register file.
- tgt_idx  input  IDX_W  index into the branch-target table.
- pc  output  PC_W  instruction-memory address.
- taken  output  1  a redirect was applied this cycle (combinational).
- done  output  1  high while in the DONE state.
- retired  output  CNT_W  count of instructions retired in the current run.

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous and active-high. While Reset is asserted:
  - state = IDLE, pc = 0, retired = 0, done = 0.
  - taken reads 0, because it is gated by state RUN.
- States: IDLE, RUN, DONE.
- IDLE:
  - pc holds 0.
  - start moves to RUN next cycle; pc stays 0.
  - All instruction inputs are ignored.
- RUN, evaluated every cycle, in priority order:
  1. stall=1: pc, retired and state hold; taken=0.
  2. halt=1: go to DONE; pc holds; retired increments (halt counts as retired).
  3. jmp=1, or br_en=1 with (cmp XOR br_ne)=1: taken=1; pc <= target(tgt_idx); retired increments.
  4. Otherwise: pc <= pc+1, wrapping modulo 2^PC_W (address 2^PC_W-1 wraps to 0); retired increments.
- DONE:
  - done=1; pc and retired hold.
  - start clears retired, sets pc=0 and returns to RUN next cycle.
- Simultaneous inputs:
  - jmp and br_en both high: jmp wins, so the redirect is unconditional.
  - halt together with jmp or br_en: halt wins.
  - start in RUN is ignored.
- Branch timing: resolution is zero-bubble. taken and the next pc depend only on the current-cycle inputs; the redirected pc is visible the cycle after.
- retired: saturates at 2^CNT_W-1; it does not wrap.
- Reset mid-run: takes effect immediately and asynchronously. No partial update survives.
- Branch-target table:
  - Combinational and read-only; 2^IDX_W entries of PC_W bits each.
  - Contents are fixed in the package.
  - Unlisted entries are 0.

Decomposition:
- Package cpu_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - PC_W, IDX_W and CNT_W defaults;
  - the branch-target constant array BR_TARGETS.
- Sub-module branch_lut: combinational, tgt_idx in, target PC out, reading BR_TARGETS.
- fetch_pc contains the FSM, the PC register, the retire counter and the next-PC mux.

Test Plan:
- Reset and start: assert Reset mid-run at pc=7 → pc=0, done=0, retired=0 immediately. Release Reset, pulse start, run 5 plain instructions → pc=5, retired=5.
- Conditional branches: BR_TARGETS[3]=40, tgt_idx=3, br_en=1.
  - br_ne=0, cmp=1 → taken=1, next pc=40.
  - br_ne=0, cmp=0 → taken=0, pc+1.
  - br_ne=1, cmp=0 → taken=1.
- Priority: stall=1 together with jmp=1 at pc=12 → pc stays 12, retired unchanged, taken=0. Drop stall → pc=BR_TARGETS[tgt_idx].
- Halt and restart: halt with jmp=1 at pc=20 after 20 retires → DONE, done=1, pc=20, retired=21. Then start → RUN, pc=0, retired=0.
- Wrap: PC_W=4, pc=15, plain instruction → pc=0.
- Saturation: CNT_W=4, 20 plain instructions → retired=15.
